// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame sequencer for a streaming radix-4 SDF FFT (4 samples/beat, N/4 beats/frame)
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   in_valid, in_last         source beat handshake; in_ready accepts the beat
//   fft_input_en, pad_zero    pipeline input enable and zero-pad mux select
//   fft_output_en             pipeline output enable, framed into out_sop/out_eop/frame_done
//   sink_credit_return        sink freed a frame buffer; credits counts free buffers
//   frames_in_flight, busy    launched frames not yet fully output, activity flag
//   err_*                     sticky protocol errors, cleared by err_clear (set wins)
module fft_frame_ctrl #(
  parameter int Num_of_samples = 4096,
  parameter int SINK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       fft_input_en,
  output logic       pad_zero,
  input  logic       fft_output_en,
  output logic       out_sop,
  output logic       out_eop,
  output logic       frame_done,
  input  logic       sink_credit_return,
  output logic [3:0] credits,
  output logic [3:0] frames_in_flight,
  output logic       busy,
  output logic       err_underrun,
  output logic       err_framing,
  output logic       err_spurious,
  output logic       err_credit,
  input  logic       err_clear
);
  localparam int BEATS = Num_of_samples / 4;
  localparam int CW = $clog2(BEATS);
  localparam logic [3:0] FULL = 4'(SINK_FRAMES);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] in_cnt, out_cnt;
  logic last_beat, launch, ret_ok, eop_dec;
  logic underrun_c, framing_c, spurious_c, credit_c;
  always_comb begin
    last_beat = state == RUN && in_cnt == CW'(BEATS - 1);
    // relaunch at the last beat keeps the pipeline fed with no bubble
    launch = in_valid && credits != 4'd0 && (state == IDLE || last_beat);
    state_nx = launch ? RUN : last_beat ? IDLE : state;
    in_ready = state == RUN;
    fft_input_en = state == RUN;
    pad_zero = state == RUN && !in_valid;
    out_sop = fft_output_en && out_cnt == '0;
    out_eop = fft_output_en && out_cnt == CW'(BEATS - 1);
    eop_dec = out_eop && frames_in_flight != 4'd0;
    // a return with a full counter is dropped unless a launch consumes a credit this cycle
    ret_ok = sink_credit_return && (launch || credits != FULL);
    busy = state == RUN || frames_in_flight != 4'd0;
    underrun_c = state == RUN && !in_valid;
    framing_c = state == RUN && in_valid && in_last != last_beat;
    spurious_c = fft_output_en && frames_in_flight == 4'd0;
    credit_c = sink_credit_return && !launch && credits == FULL;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      in_cnt <= '0;
      out_cnt <= '0;
      credits <= FULL;
      frames_in_flight <= 4'd0;
      frame_done <= 1'b0;
      err_underrun <= 1'b0;
      err_framing <= 1'b0;
      err_spurious <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      // BEATS is a power of two, so the counters wrap naturally at frame end
      in_cnt <= state == RUN ? in_cnt + 1'b1 : '0;
      out_cnt <= fft_output_en ? out_cnt + 1'b1 : out_cnt;
      credits <= credits + 4'(ret_ok) - 4'(launch);
      frames_in_flight <= frames_in_flight + 4'(launch) - 4'(eop_dec);
      frame_done <= out_eop;
      err_underrun <= (err_underrun && !err_clear) || underrun_c;
      err_framing <= (err_framing && !err_clear) || framing_c;
      err_spurious <= (err_spurious && !err_clear) || spurious_c;
      err_credit <= (err_credit && !err_clear) || credit_c;
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed bench for fft_frame_ctrl with a frame-level reference model
// Ports: none; drives clock/reset and all DUT inputs, models the pipeline as an L-cycle delay.
module tb_fft_frame_ctrl;
  localparam int N = 64, BEATS = 16, SF = 2, L = 5;
  logic clock = 0, reset = 1;
  logic in_valid = 0, in_last = 0, sink_credit_return = 0, err_clear = 0, force_oen = 0;
  logic in_ready, fft_input_en, pad_zero, fft_output_en, out_sop, out_eop, frame_done, busy;
  logic err_underrun, err_framing, err_spurious, err_credit;
  logic [3:0] credits, frames_in_flight;
  logic [L-1:0] pipe = '0;
  int checks = 0, errors = 0;
  int en_cnt = 0, pad_cnt = 0, sop_cnt = 0, eop_cnt = 0, done_cnt = 0;
  int m_left, m_cred, m_fif, m_opos;
  logic m_done;
  logic [3:0] m_err;
  bit run, at_end, go, eop, started = 0;

  fft_frame_ctrl #(.Num_of_samples(N), .SINK_FRAMES(SF)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .fft_input_en(fft_input_en), .pad_zero(pad_zero), .fft_output_en(fft_output_en),
    .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done),
    .sink_credit_return(sink_credit_return), .credits(credits), .frames_in_flight(frames_in_flight),
    .busy(busy), .err_underrun(err_underrun), .err_framing(err_framing), .err_spurious(err_spurious),
    .err_credit(err_credit), .err_clear(err_clear));

  always #5 clock = ~clock;
  assign fft_output_en = (pipe[L-1] && !reset) || force_oen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // pipeline stand-in: output_en is input_en delayed by L cycles, flushed by reset
  initial forever begin
    @(posedge clock); #1;
    pipe = reset ? '0 : {pipe[L-2:0], fft_input_en};
  end

  // reference model: a frame is BEATS cycles counted down in m_left
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_left = 0; m_cred = SF; m_fif = 0; m_opos = 0; m_done = 0; m_err = 0;
    end else begin
      run = m_left > 0;
      at_end = m_left == 1;
      go = in_valid && m_cred > 0 && (!run || at_end);
      eop = fft_output_en && m_opos == BEATS - 1;
      m_err = (m_err & {4{!err_clear}}) | {run && !in_valid, run && in_valid && (in_last != at_end),
                                           fft_output_en && m_fif == 0, sink_credit_return && !go && m_cred == SF};
      m_left = go ? BEATS : run ? m_left - 1 : 0;
      m_cred = m_cred - int'(go) + int'(sink_credit_return && (go || m_cred < SF));
      m_fif = m_fif + int'(go) - int'(eop && m_fif > 0);
      m_opos = fft_output_en ? (m_opos + 1) % BEATS : m_opos;
      m_done = eop;
    end
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      en_cnt += int'(fft_input_en); pad_cnt += int'(pad_zero);
      sop_cnt += int'(out_sop); eop_cnt += int'(out_eop); done_cnt += int'(frame_done);
      if (started) begin
        chk("in_ready", in_ready, m_left > 0);
        chk("fft_input_en", fft_input_en, m_left > 0);
        chk("pad_zero", pad_zero, m_left > 0 && !in_valid);
        chk("out_sop", out_sop, fft_output_en && m_opos == 0);
        chk("out_eop", out_eop, fft_output_en && m_opos == BEATS - 1);
        chk("frame_done", frame_done, m_done);
        chk("credits", credits, m_cred);
        chk("frames_in_flight", frames_in_flight, m_fif);
        chk("busy", busy, m_left > 0 || m_fif != 0);
        chk("err_flags", {err_underrun, err_framing, err_spurious, err_credit}, m_err);
        chk("invariant", int'(credits) + int'(frames_in_flight) <= SF, 1);
      end
    end
  end

  task automatic tick(); @(posedge clock); #2; endtask
  task automatic zero(); en_cnt = 0; pad_cnt = 0; sop_cnt = 0; eop_cnt = 0; done_cnt = 0; endtask
  task automatic launch(); in_valid = 1; in_last = 0; tick(); endtask
  task automatic ret(); sink_credit_return = 1; tick(); sink_credit_return = 0; endtask
  task automatic clr(); err_clear = 1; tick(); err_clear = 0; endtask
  task automatic beats(input int n, input int gap_lo, input int gap_hi, input int last_at);
    for (int k = 0; k < n; k++) begin
      in_valid = !(k >= gap_lo && k <= gap_hi);
      in_last = (k % BEATS) == last_at;
      tick();
    end
    in_valid = 0; in_last = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((frames_in_flight != 0 || pipe != 0 || frame_done || fft_input_en) && n < 100) begin
      tick(); n++;
    end
    chk("drain_timeout", n < 100, 1);
    tick();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #2 reset = 0; started = 1;
    chk("rst_outs", {in_ready, fft_input_en, pad_zero, out_sop, out_eop, frame_done, busy,
                     err_underrun, err_framing, err_spurious, err_credit}, 0);
    chk("rst_credits", credits, 2);
    chk("rst_fif", frames_in_flight, 0);
    // back-to-back: two frames with no bubble, then credit-blocked third frame
    zero(); launch();
    chk("b2b_launch_en", fft_input_en, 1);
    chk("b2b_launch_credits", credits, 1);
    beats(32, -1, -1, 15);
    chk("b2b_en_cycles", en_cnt, 32);
    chk("b2b_idle", fft_input_en, 0);
    chk("b2b_credits", credits, 0);
    in_valid = 1;
    repeat (3) tick();
    chk("blocked_no_launch", fft_input_en, 0);
    drain();
    chk("b2b_sop", sop_cnt, 2);
    chk("b2b_eop", eop_cnt, 2);
    chk("b2b_done", done_cnt, 2);
    ret();
    chk("ret_still_idle", fft_input_en, 0);
    chk("ret_credits", credits, 1);
    tick();
    chk("launch_after_ret", fft_input_en, 1);
    chk("launch_after_ret_credits", credits, 0);
    beats(16, -1, -1, 15);
    drain(); ret();
    // single clean frame
    zero(); launch(); beats(16, -1, -1, 15); drain();
    chk("single_en", en_cnt, 16);
    chk("single_sop", sop_cnt, 1);
    chk("single_eop", eop_cnt, 1);
    chk("single_done", done_cnt, 1);
    chk("single_errs", {err_underrun, err_framing, err_spurious, err_credit}, 0);
    ret();
    // underrun on beats 5-6
    zero(); launch(); beats(16, 5, 6, 15);
    chk("underrun_pad", pad_cnt, 2);
    chk("underrun_en", en_cnt, 16);
    chk("underrun_flag", err_underrun, 1);
    drain(); ret();
    chk("underrun_sticky", err_underrun, 1);
    clr();
    chk("underrun_cleared", err_underrun, 0);
    // early in_last on beat 9
    zero(); launch(); beats(16, -1, -1, 9);
    chk("framing_flag", err_framing, 1);
    chk("framing_en", en_cnt, 16);
    drain(); ret(); clr();
    chk("framing_cleared", err_framing, 0);
    // launch coinciding with out_eop
    launch(); beats(16, -1, -1, 15); ret();
    n = 0;
    while (!out_eop && n < 50) begin tick(); n++; end
    chk("eop_wait", n < 50, 1);
    in_valid = 1; tick();
    chk("eop_launch_fif", frames_in_flight, 1);
    chk("eop_launch_credits", credits, 0);
    beats(16, -1, -1, 15); drain(); ret();
    // launch coinciding with credit return
    in_valid = 1; sink_credit_return = 1; tick(); sink_credit_return = 0;
    chk("ret_launch_credits", credits, 1);
    chk("ret_launch_en", fft_input_en, 1);
    beats(32, -1, -1, 15); drain();
    // over-return
    ret(); ret();
    chk("full_credits", credits, 2);
    ret();
    chk("over_ret_flag", err_credit, 1);
    chk("over_ret_credits", credits, 2);
    clr();
    chk("credit_cleared", err_credit, 0);
    // asynchronous reset mid-frame at beat 8
    launch(); beats(8, -1, -1, 15);
    reset = 1; #1;
    chk("async_rst_outs", {in_ready, fft_input_en, pad_zero, out_sop, out_eop, frame_done, busy,
                           err_underrun, err_framing, err_spurious, err_credit}, 0);
    chk("async_rst_credits", credits, 2);
    chk("async_rst_fif", frames_in_flight, 0);
    tick(); tick(); reset = 0;
    zero(); launch(); beats(32, -1, -1, 15); drain();
    chk("post_rst_en", en_cnt, 32);
    chk("post_rst_done", done_cnt, 2);
    chk("post_rst_errs", {err_underrun, err_framing, err_spurious, err_credit}, 0);
    // output enable with nothing in flight
    force_oen = 1; tick(); force_oen = 0;
    chk("spurious_flag", err_spurious, 1);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame-level sequencer for the streaming radix-4 SDF FFT pipeline: 4 complex samples per beat, N/4 beats per frame.
- Accepts beats from a valid/ready source and drives the pipeline's input enable. The pipeline cannot stall, so each frame is gap-free; source gaps are padded with zeros.
- Launches a frame only when the downstream sink has a free frame credit.
- Frames pipeline output_en into sop/eop/done, tracks frames in flight and keeps sticky protocol-error flags.

Parameters:
- Num_of_samples, 4096, FFT length N; power of 4, >=16; BEATS = N/4 (localparam).
- SINK_FRAMES, 2, frame buffers available downstream (initial credit count), 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  source beat valid.
- in_last  in  1  source marks last beat of frame.
- in_ready  out  1  controller accepts beat.
- fft_input_en  out  1  drives pipeline input_en.
- pad_zero  out  1  datapath mux feeds zeros to pipeline this cycle.
- fft_output_en  in  1  pipeline output_en.
- out_sop  out  1  first output beat of frame.
- out_eop  out  1  last output beat of frame.
- frame_done  out  1  one-cycle pulse, cycle after out_eop.
- sink_credit_return  in  1  pulse: sink freed one frame buffer.
- credits  out  4  available sink credits.
- frames_in_flight  out  4  launched frames whose output has not finished.
- busy  out  1  state==RUN or frames_in_flight!=0.
- err_underrun  out  1  sticky: source gap inside frame.
- err_framing  out  1  sticky: in_last misplaced.
- err_spurious  out  1  sticky: fft_output_en with no frame in flight.
- err_credit  out  1  sticky: credit return would exceed SINK_FRAMES.
- err_clear  in  1  synchronous clear of all sticky errors.

Behaviour:
- Reset (async): state=IDLE, in_cnt=0, out_cnt=0, credits=SINK_FRAMES, frames_in_flight=0, all outputs 0. Reset mid-frame drops the frame; the top resets the pipeline with the same signal.
- FSM state IDLE: in_ready=0, fft_input_en=0. If in_valid && credits>0: launch (credits-1, frames_in_flight+1), go RUN next cycle with in_cnt=0.
- FSM state RUN: in_ready=1, fft_input_en=1 every cycle, pad_zero=~in_valid, in_cnt increments every cycle.
  - At in_cnt==BEATS-1: if in_valid && credits>0 (post-update value), relaunch back-to-back (in_cnt=0, stay RUN, no bubble). Otherwise go to IDLE.
- A frame in RUN always lasts exactly BEATS cycles.
- Underrun: in RUN with in_valid=0 -> set err_underrun; the beat is zero-padded; the frame is not extended.
- Framing: an accepted beat with in_last != (in_cnt==BEATS-1) -> set err_framing. An early in_last does not truncate; remaining beats are consumed normally. Zero-padded beats are not framing-checked.
- Output side:
  - out_cnt increments on each fft_output_en and wraps at BEATS-1.
  - out_sop = fft_output_en && out_cnt==0 (combinational).
  - out_eop = fft_output_en && out_cnt==BEATS-1 (combinational).
  - On out_eop: frames_in_flight-1; frame_done registered, high for the next cycle.
- Spurious output: fft_output_en while frames_in_flight==0 -> set err_spurious; out_cnt still advances.
- Credit counter:
  - Launch: -1. sink_credit_return: +1. Same cycle: unchanged.
  - Return while credits==SINK_FRAMES (no launch same cycle) -> counter holds, set err_credit.
- frames_in_flight: launch and eop in the same cycle -> unchanged.
- Invariant: credits + frames_in_flight <= SINK_FRAMES; the bench checks it every cycle.
- err_clear: clears all sticky flags. If an error condition occurs in the same cycle as err_clear, the flag is set (set wins).
- Latency: IDLE to first fft_input_en = 1 cycle after launch condition. in_ready and fft_input_en are registered-state decodes with no combinational path from in_valid. pad_zero is combinational from in_valid.

Test Plan (Num_of_samples=64, BEATS=16, SINK_FRAMES=2):
- Single frame: in_valid held for 16 beats, in_last on beat 15; pipeline model asserts output_en 16 cycles at latency L -> fft_input_en exactly 16 cycles; out_sop on 1st and out_eop on 16th output beat; frame_done 1 cycle later; credits 2->1; frames_in_flight 0->1->0; no errors.
- Back-to-back: 3 frames continuous, no credit returns -> frames 1 and 2 launch with no bubble; RUN->IDLE after 32 beats; frame 3 launches 1 cycle after a sink_credit_return pulse.
- Underrun: in_valid dropped on beats 5-6 -> pad_zero=1 on those cycles; frame still 16 cycles; err_underrun=1 until err_clear.
- Framing: in_last on beat 9 -> err_framing=1; frame continues to 16 beats.
- Simultaneous events: launch with sink_credit_return same cycle -> credits unchanged. Launch with out_eop same cycle -> frames_in_flight unchanged. Extra return at credits=2 -> err_credit=1, credits stays 2.
- Reset mid-frame at beat 8: async reset -> in the same cycle all outputs 0, credits=2, state IDLE. Next frame runs cleanly. fft_output_en with nothing in flight -> err_spurious=1.
